// File: rtl/accum_pkg.sv
//------------------------------------------------------------------------------
// Module   : accum_pkg
// Brief    : Shared state encoding and default width for the accumulator block.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package accum_pkg;

  localparam int c_acc_w = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    CLEAR = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/accum_ctrl_debounce.sv
//------------------------------------------------------------------------------
// Module   : key_debounce
// Brief    : 2-flop synchronizer plus stability counter for one active-low key.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press
);

  localparam int                 c_cnt_w   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic [1:0]         r_sync;
  logic [1:0]         r_fill;
  logic               r_armed;
  logic               r_level;
  logic               r_press;
  logic [c_cnt_w-1:0] r_cnt;

  // Presses only count once the key has been seen released after reset,
  // so a key held through reset cannot fire an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_fill  <= 2'b00;
      r_armed <= 1'b0;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_key_n};
      r_fill  <= {r_fill[0], 1'b1};
      r_press <= 1'b0;
      if (r_fill[1] && r_sync[1]) begin
        r_armed <= 1'b1;
      end
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_max) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
        r_press <= r_armed && !r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

`default_nettype wire

// File: rtl/accum_ctrl.sv
//------------------------------------------------------------------------------
// Module   : accum_ctrl
// Brief    : Key-driven accumulator with sticky overflow and LED output mux.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module accum_ctrl
  import accum_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACC_W           = c_acc_w
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       KEY,
  input  logic [ACC_W-1:0] SW,
  input  logic [ACC_W-1:0] pio_led,
  input  logic             sel_hw,
  output logic [ACC_W-1:0] LEDR,
  output logic [ACC_W-1:0] acc,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  logic [1:0]       w_level;
  logic [1:0]       w_press;
  logic [ACC_W:0]   w_sum;
  state_t           r_state;
  state_t           w_next;
  logic [ACC_W-1:0] r_acc;
  logic             r_overflow;
  logic [ACC_W-1:0] r_ledr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk    (Clk),
      .rst    (Reset),
      .i_key_n(KEY[gi]),
      .o_level(w_level[gi]),
      .o_press(w_press[gi])
    );
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Clear wins over a simultaneous accumulate press.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_press[0]) begin
          w_next = CLEAR;
        end else if (w_press[1]) begin
          w_next = ADD;
        end
      end
      ADD:     w_next = HOLD;
      CLEAR:   w_next = HOLD;
      HOLD: begin
        if (&w_level) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_sum = {1'b0, r_acc} + {1'b0, SW};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_acc      <= '0;
      r_overflow <= 1'b0;
      r_ledr     <= '0;
    end else begin
      if (r_state == ADD) begin
        r_acc      <= w_sum[ACC_W-1:0];
        r_overflow <= r_overflow | w_sum[ACC_W];
      end else if (r_state == CLEAR) begin
        r_acc      <= '0;
        r_overflow <= 1'b0;
      end
      r_ledr <= sel_hw ? r_acc : pio_led;
    end
  end

  assign acc      = r_acc;
  assign overflow = r_overflow;
  assign LEDR     = r_ledr;
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == ADD) || (r_state == CLEAR);

endmodule

`default_nettype wire
